// File: rtl/saturn_bus_ctrl.sv
// ---------------------------------------------------------------------------
// saturn_bus_ctrl
// Executes a small bus program written by the control unit. Each entry is
// either a command nibble (bit4=1, bits3:0 = BUSCMD code) or a data nibble.
// At most one transfer happens per 4-phase cycle. The decision is taken on
// the phase-0 edge, the strobe is visible for the phase-1 clock, and the
// read pointer advances on the phase-1 edge. Reads sample the bus on the
// phase-2 edge.
//
// Ports
//   i_clk              system clock, rising edge
//   i_reset            asynchronous active-high reset
//   i_phases[3:0]      one-hot phase strobe
//   i_debug_cycle      freeze all state while high
//   i_program_data     bus program entry at o_program_address
//   i_program_address  control-unit write pointer (next free slot)
//   o_program_address  read pointer into the bus program
//   o_bus_data         nibble driven on the bus
//   o_bus_cmd_data     high = command nibble
//   o_bus_strobe       one-clock transfer strobe
//   i_bus_data         nibble returned by the bus on reads
//   o_nibble           last fetched nibble
//   o_nibble_valid     one-clock pulse when o_nibble updates
//   o_bus_busy         entry pending or address load in progress
//   o_bus_pc           local copy of the bus PC
//   o_error            sticky protocol error
// ---------------------------------------------------------------------------
module saturn_bus_ctrl (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [3:0]  i_phases,
    input  logic        i_debug_cycle,
    input  logic [4:0]  i_program_data,
    input  logic [4:0]  i_program_address,
    output logic [4:0]  o_program_address,
    output logic [3:0]  o_bus_data,
    output logic        o_bus_cmd_data,
    output logic        o_bus_strobe,
    input  logic [3:0]  i_bus_data,
    output logic [3:0]  o_nibble,
    output logic        o_nibble_valid,
    output logic        o_bus_busy,
    output logic [19:0] o_bus_pc,
    output logic        o_error
);

    localparam logic [3:0] CMD_PC_READ = 4'h0;
    localparam logic [3:0] CMD_LOAD_PC = 4'h4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_READ,
        S_ERROR
    } state_t;

    state_t      r_state;
    state_t      r_cmd_next;     // where CMD goes once its strobe is done
    logic [4:0]  r_ptr;
    logic [2:0]  r_count;        // address nibbles loaded so far
    logic [19:0] r_pc;
    logic [3:0]  r_nibble;
    logic        r_valid;
    logic        r_strobe;
    logic        r_cmd_data;
    logic [3:0]  r_data;
    logic        r_error;
    logic        r_consume;      // current strobe consumed a program entry
    logic        r_sample;       // current strobe is a read awaiting phase 2

    // Phases are only honoured when the strobe is cleanly one-hot, so a
    // glitchy multi-hot phase vector cannot trigger two actions at once.
    logic w_ph0, w_ph1, w_ph2;
    logic w_pending, w_is_cmd, w_code_ok;
    logic [3:0] w_code;

    assign w_ph0     = (i_phases == 4'b0001);
    assign w_ph1     = (i_phases == 4'b0010);
    assign w_ph2     = (i_phases == 4'b0100);
    assign w_pending = (r_ptr != i_program_address);
    assign w_is_cmd  = i_program_data[4];
    assign w_code    = i_program_data[3:0];
    assign w_code_ok = (w_code == CMD_PC_READ) || (w_code == CMD_LOAD_PC);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_cmd_next <= S_IDLE;
            r_ptr      <= 5'd0;
            r_count    <= 3'd0;
            r_pc       <= 20'd0;
            r_nibble   <= 4'd0;
            r_valid    <= 1'b0;
            r_strobe   <= 1'b0;
            r_cmd_data <= 1'b0;
            r_data     <= 4'd0;
            r_error    <= 1'b0;
            r_consume  <= 1'b0;
            r_sample   <= 1'b0;
        end else if (!i_debug_cycle) begin
            // Pulses last one clock unless re-armed below.
            r_strobe <= 1'b0;
            r_valid  <= 1'b0;

            if (w_ph1) begin
                if (r_strobe && r_consume) begin
                    r_ptr     <= r_ptr + 5'd1;   // natural 31->0 wrap
                    r_consume <= 1'b0;
                end
                if (r_state == S_CMD) begin
                    r_state <= r_cmd_next;
                end
            end

            if (w_ph2 && r_sample) begin
                r_nibble <= i_bus_data;
                r_valid  <= 1'b1;
                r_pc     <= r_pc + 20'd1;
                r_sample <= 1'b0;
            end

            if (w_ph0) begin
                case (r_state)
                    S_IDLE, S_READ: begin
                        if (w_pending) begin
                            // A pending command beats a background read.
                            if (!w_is_cmd || !w_code_ok) begin
                                r_state <= S_ERROR;
                                r_error <= 1'b1;
                            end else begin
                                r_strobe   <= 1'b1;
                                r_cmd_data <= 1'b1;
                                r_data     <= w_code;
                                r_consume  <= 1'b1;
                                r_state    <= S_CMD;
                                r_count    <= 3'd0;
                                r_cmd_next <= (w_code == CMD_LOAD_PC) ? S_ADDR : S_READ;
                            end
                        end else if (r_state == S_READ) begin
                            r_strobe   <= 1'b1;
                            r_cmd_data <= 1'b0;
                            r_data     <= 4'd0;
                            r_sample   <= 1'b1;
                        end
                    end
                    S_ADDR: begin
                        if (w_pending) begin
                            if (w_is_cmd) begin
                                r_state <= S_ERROR;
                                r_error <= 1'b1;
                            end else begin
                                r_strobe   <= 1'b1;
                                r_cmd_data <= 1'b0;
                                r_data     <= i_program_data[3:0];
                                r_consume  <= 1'b1;
                                r_pc[{r_count, 2'b00} +: 4] <= i_program_data[3:0];
                                r_count    <= r_count + 3'd1;
                                if (r_count == 3'd4) begin
                                    r_state <= S_READ;
                                end
                            end
                        end
                    end
                    default: ;   // CMD waits for phase 1, ERROR is terminal
                endcase
            end
        end
    end

    assign o_program_address = r_ptr;
    assign o_bus_data        = r_data;
    assign o_bus_cmd_data    = r_cmd_data;
    assign o_bus_strobe      = r_strobe;
    assign o_nibble          = r_nibble;
    assign o_nibble_valid    = r_valid;
    assign o_bus_pc          = r_pc;
    assign o_error           = r_error;
    assign o_bus_busy        = w_pending || (r_state == S_ADDR);

endmodule

// File: tb/tb_saturn_bus_ctrl.sv
module tb_saturn_bus_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic [3:0]  i_phases;
    logic        i_debug_cycle = 1'b0;
    logic [4:0]  i_program_data;
    logic [4:0]  i_program_address = 5'd0;
    logic [4:0]  o_program_address;
    logic [3:0]  o_bus_data;
    logic        o_bus_cmd_data;
    logic        o_bus_strobe;
    logic [3:0]  i_bus_data = 4'd0;
    logic [3:0]  o_nibble;
    logic        o_nibble_valid;
    logic        o_bus_busy;
    logic [19:0] o_bus_pc;
    logic        o_error;

    saturn_bus_ctrl dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_phases          (i_phases),
        .i_debug_cycle     (i_debug_cycle),
        .i_program_data    (i_program_data),
        .i_program_address (i_program_address),
        .o_program_address (o_program_address),
        .o_bus_data        (o_bus_data),
        .o_bus_cmd_data    (o_bus_cmd_data),
        .o_bus_strobe      (o_bus_strobe),
        .i_bus_data        (i_bus_data),
        .o_nibble          (o_nibble),
        .o_nibble_valid    (o_nibble_valid),
        .o_bus_busy        (o_bus_busy),
        .o_bus_pc          (o_bus_pc),
        .o_error           (o_error)
    );

    always #5 i_clk = ~i_clk;

    // Free-running 4-phase generator.
    logic [1:0] ph = 2'd0;
    always @(posedge i_clk) ph <= ph + 2'd1;
    assign i_phases = 4'b0001 << ph;

    // Bus program memory owned by the bench.
    logic [4:0] mem [32];
    assign i_program_data = mem[o_program_address];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transfer log and bus responder.
    int         n_strobe = 0;
    int         n_nib    = 0;
    logic [4:0] slog [64];
    logic [3:0] nlog [64];
    logic [3:0] rd_vals [4];
    int         rd_len = 0;
    int         rd_n   = 0;

    initial begin
        forever begin
            @(negedge i_clk);
            if (o_bus_strobe === 1'b1) begin
                chk("strobe_in_phase1", {28'd0, i_phases}, 32'h2);
                if (n_strobe < 64) slog[n_strobe] = {o_bus_cmd_data, o_bus_data};
                n_strobe++;
                if (!o_bus_cmd_data && rd_n < rd_len) begin
                    i_bus_data = rd_vals[rd_n];
                    rd_n++;
                end
            end
            if (o_nibble_valid === 1'b1) begin
                if (n_nib < 64) nlog[n_nib] = o_nibble;
                n_nib++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge i_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        i_reset           = 1'b1;
        i_program_address = 5'd0;
        i_debug_cycle     = 1'b0;
        rd_len            = 0;
        rd_n              = 0;
        i_bus_data        = 4'd0;
        for (int i = 0; i < 32; i++) mem[i] = 5'h00;
        step(2);
        n_strobe = 0;
        n_nib    = 0;
        i_reset  = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int bound, input string name);
        int k = 0;
        while (n_strobe < n && k < bound) begin
            step(1);
            k++;
        end
        chk(name, {31'd0, n_strobe >= n}, 32'd1);
    endtask

    task automatic wait_ptr(input logic [4:0] p, input int bound, input string name);
        int k = 0;
        while (o_program_address !== p && k < bound) begin
            step(1);
            k++;
        end
        chk(name, {27'd0, o_program_address}, {27'd0, p});
    endtask

    task automatic load_req027();
        mem[0] = 5'h14; mem[1] = 5'h05; mem[2] = 5'h04;
        mem[3] = 5'h03; mem[4] = 5'h02; mem[5] = 5'h01;
    endtask

    task automatic check_req027(input string tag);
        logic [4:0] exp_log [6];
        exp_log[0] = 5'h14; exp_log[1] = 5'h05; exp_log[2] = 5'h04;
        exp_log[3] = 5'h03; exp_log[4] = 5'h02; exp_log[5] = 5'h01;
        wait_strobes(6, 120, {tag, "_wait6"});
        for (int i = 0; i < 6; i++)
            chk($sformatf("%s_strobe%0d", tag, i), {27'd0, slog[i]}, {27'd0, exp_log[i]});
        chk({tag, "_pc"}, {12'd0, o_bus_pc}, 32'h12345);
        chk({tag, "_err"}, {31'd0, o_error}, 32'd0);
    endtask

    typedef struct {
        logic [5:0][4:0] prog;     // entry 0 in the low slot
        logic [4:0]      np;
        logic [4:0]      exp_ptr;
        int              exp_str;
        logic            exp_err;
        logic            exp_busy;
        logic [19:0]     exp_pc;
    } vec_t;

    vec_t vecs [6];

    initial begin
        // Table: each program runs from reset for 12 phase cycles.
        vecs[0] = '{prog: {5'h00, 5'h00, 5'h03, 5'h04, 5'h05, 5'h14}, np: 5'd4,
                    exp_ptr: 5'd4, exp_str: 4, exp_err: 1'b0, exp_busy: 1'b1, exp_pc: 20'h00345};
        vecs[1] = '{prog: {5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h17}, np: 5'd1,
                    exp_ptr: 5'd0, exp_str: 0, exp_err: 1'b1, exp_busy: 1'b1, exp_pc: 20'h0};
        vecs[2] = '{prog: {5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h05}, np: 5'd1,
                    exp_ptr: 5'd0, exp_str: 0, exp_err: 1'b1, exp_busy: 1'b1, exp_pc: 20'h0};
        vecs[3] = '{prog: {5'h00, 5'h00, 5'h00, 5'h14, 5'h05, 5'h14}, np: 5'd3,
                    exp_ptr: 5'd2, exp_str: 2, exp_err: 1'b1, exp_busy: 1'b1, exp_pc: 20'h00005};
        vecs[4] = '{prog: {5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00}, np: 5'd0,
                    exp_ptr: 5'd0, exp_str: 0, exp_err: 1'b0, exp_busy: 1'b0, exp_pc: 20'h0};
        vecs[5] = '{prog: {5'h00, 5'h00, 5'h00, 5'h0B, 5'h0A, 5'h14}, np: 5'd3,
                    exp_ptr: 5'd3, exp_str: 3, exp_err: 1'b0, exp_busy: 1'b1, exp_pc: 20'h000BA};

        for (int i = 0; i < 32; i++) mem[i] = 5'h00;

        // Asynchronous reset before any clock edge.
        #2 i_reset = 1'b1;
        #1;
        chk("rst_ptr",    {27'd0, o_program_address}, 32'd0);
        chk("rst_pc",     {12'd0, o_bus_pc}, 32'd0);
        chk("rst_strobe", {31'd0, o_bus_strobe}, 32'd0);
        chk("rst_cmd",    {31'd0, o_bus_cmd_data}, 32'd0);
        chk("rst_data",   {28'd0, o_bus_data}, 32'd0);
        chk("rst_nib",    {28'd0, o_nibble}, 32'd0);
        chk("rst_valid",  {31'd0, o_nibble_valid}, 32'd0);
        chk("rst_err",    {31'd0, o_error}, 32'd0);
        chk("rst_busy",   {31'd0, o_bus_busy}, 32'd0);

        // Table-driven programs.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int e = 0; e < 6; e++) mem[e] = vecs[v].prog[e];
            i_program_address = vecs[v].np;
            step(48);
            chk($sformatf("v%0d_ptr", v), {27'd0, o_program_address}, {27'd0, vecs[v].exp_ptr});
            chk($sformatf("v%0d_strobes", v), n_strobe, vecs[v].exp_str);
            chk($sformatf("v%0d_err", v), {31'd0, o_error}, {31'd0, vecs[v].exp_err});
            chk($sformatf("v%0d_busy", v), {31'd0, o_bus_busy}, {31'd0, vecs[v].exp_busy});
            chk($sformatf("v%0d_pc", v), {12'd0, o_bus_pc}, {12'd0, vecs[v].exp_pc});
        end

        // Full LOAD_PC, then three reads, then a PC_READ while reading.
        do_reset();
        load_req027();
        i_program_address = 5'd6;
        check_req027("load");
        rd_vals[0] = 4'hA; rd_vals[1] = 4'hB; rd_vals[2] = 4'hC;
        rd_len = 3;
        begin
            int k = 0;
            while (n_nib < 3 && k < 60) begin
                step(1);
                k++;
            end
        end
        chk("read_count", {31'd0, n_nib >= 3}, 32'd1);
        chk("read_nib0", {28'd0, nlog[0]}, 32'hA);
        chk("read_nib1", {28'd0, nlog[1]}, 32'hB);
        chk("read_nib2", {28'd0, nlog[2]}, 32'hC);
        chk("read_pc", {12'd0, o_bus_pc}, 32'h12348);
        chk("read_busy", {31'd0, o_bus_busy}, 32'd0);
        mem[6] = 5'h10;
        i_program_address = 5'd7;
        wait_ptr(5'd7, 20, "pcread_ptr");
        chk("pcread_err", {31'd0, o_error}, 32'd0);

        // Address arriving in two parts.
        do_reset();
        mem[0] = 5'h14; mem[1] = 5'h01; mem[2] = 5'h02; mem[3] = 5'h03;
        i_program_address = 5'd4;
        step(40);
        chk("part_busy", {31'd0, o_bus_busy}, 32'd1);
        chk("part_strobes", n_strobe, 4);
        step(20);
        chk("part_stall", n_strobe, 4);
        mem[4] = 5'h04; mem[5] = 5'h05;
        i_program_address = 5'd6;
        wait_strobes(6, 20, "part_resume");
        chk("part_pc", {12'd0, o_bus_pc}, 32'h54321);

        // Debug cycle freezes everything; lost phases are not replayed.
        do_reset();
        mem[0] = 5'h14;
        i_debug_cycle = 1'b1;
        i_program_address = 5'd1;
        step(20);
        chk("dbg_ptr", {27'd0, o_program_address}, 32'd0);
        chk("dbg_strobes", n_strobe, 0);
        i_debug_cycle = 1'b0;
        wait_strobes(1, 12, "dbg_release");
        chk("dbg_cmd", {27'd0, slog[0]}, 32'h14);

        // Asynchronous reset in the middle of an address load.
        do_reset();
        load_req027();
        i_program_address = 5'd6;
        wait_strobes(4, 60, "mid_wait");
        i_reset = 1'b1;
        #1;
        chk("mid_strobe", {31'd0, o_bus_strobe}, 32'd0);
        chk("mid_ptr", {27'd0, o_program_address}, 32'd0);
        chk("mid_pc", {12'd0, o_bus_pc}, 32'd0);
        chk("mid_data", {28'd0, o_bus_data}, 32'd0);
        chk("mid_busy", {31'd0, o_bus_busy}, 32'd1);
        step(2);
        n_strobe = 0;
        n_nib    = 0;
        i_reset  = 1'b0;
        check_req027("replay");

        // Read pointer wraps from 31 to 0.
        do_reset();
        load_req027();
        for (int i = 6; i < 32; i++) mem[i] = 5'h10;
        i_program_address = 5'd30;
        wait_ptr(5'd30, 300, "wrap_reach30");
        i_program_address = 5'd0;
        wait_ptr(5'd31, 20, "wrap_31");
        wait_ptr(5'd0, 20, "wrap_0");
        chk("wrap_err", {31'd0, o_error}, 32'd0);
        chk("wrap_busy", {31'd0, o_bus_busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/saturn_bus_ctrl.md
SATURN_BUS_CTRL -- requirements
Module: saturn_bus_ctrl

Interface
REQ-001 SHALL have ports: i_clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have: i_reset  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: i_phases  in  4  one-hot phase strobe, bit n high during phase n.
REQ-004 SHALL have: i_debug_cycle  in  1  when high, all state holds.
REQ-005 SHALL have: i_program_data  in  5  bus program entry at o_program_address; bit4=1 command (bits3:0 BUSCMD code), bit4=0 data nibble.
REQ-006 SHALL have: i_program_address  in  5  control-unit write pointer (next free slot).
REQ-007 SHALL have: o_program_address  out  5  read pointer into bus program.
REQ-008 SHALL have: o_bus_data  out  4  nibble driven on bus; o_bus_cmd_data  out  1  high = command nibble; o_bus_strobe  out  1  one-clock transfer strobe.
REQ-009 SHALL have: i_bus_data  in  4  nibble returned by bus on reads.
REQ-010 SHALL have: o_nibble  out  4  last fetched nibble; o_nibble_valid  out  1  one-clock pulse.
REQ-011 SHALL have: o_bus_busy  out  1; o_bus_pc  out  20  local PC copy; o_error  out  1  sticky error.

Function
REQ-012 SHALL use BUSCMD codes: PC_READ 4'h0, LOAD_PC 4'h4; any other code is unsupported.
REQ-013 SHALL run FSM states IDLE, CMD, ADDR, READ, ERROR.
REQ-014 Pending entry exists when o_program_address != i_program_address; i_program_data is read combinationally same cycle.
REQ-015 At most one bus transfer per 4-phase cycle: decision at i_phases[0], o_bus_strobe high for exactly the i_phases[1] clock, pointer increments on that same clock.
REQ-016 CMD: pending command entry at phase 0 -> drive {cmd_data=1, code} at phase 1; LOAD_PC -> ADDR with nibble count 0; PC_READ -> READ.
REQ-017 ADDR: each pending data entry driven with cmd_data=0 and stored into o_bus_pc[count*4+:4] (LS nibble first); after 5th nibble -> READ; no pending entry -> wait, no strobe.
REQ-018 READ with no pending entry: strobe with cmd_data=0, o_bus_data=0 at phase 1; sample i_bus_data at phase 2 into o_nibble, pulse o_nibble_valid, o_bus_pc <= o_bus_pc+1 (20-bit wrap FFFFF->00000).
REQ-019 READ/IDLE with pending command entry: command takes priority over read, processed per REQ-016.
REQ-020 IDLE after reset: no strobes until first LOAD_PC.
REQ-021 o_bus_busy high when entry pending or state is ADDR; low otherwise.
REQ-022 Pointer is 5-bit, wraps 31->0 without error.
REQ-023 Errors -> ERROR (sticky, o_error=1, no strobes, pointer frozen): command entry while in ADDR; data entry outside ADDR; unsupported command code.
REQ-024 i_debug_cycle high: no state, pointer, output-register change; phase strobe during it is lost, not deferred.

Reset
REQ-025 i_reset high asynchronously forces: state IDLE, pointer 0, nibble count 0, o_bus_pc 0, o_nibble 0, o_nibble_valid 0, o_bus_strobe 0, o_bus_cmd_data 0, o_bus_data 0, o_error 0; o_bus_busy derived accordingly.
REQ-026 Reset mid-ADDR or mid-READ discards partial address and any unsampled nibble; operation restarts from IDLE on release.

Verification
REQ-027 Program {1_4,0_5,0_4,0_3,0_2,0_1}, write ptr 6 -> 6 strobes: cmd 4 then data 5,4,3,2,1; o_bus_pc=12345; then READ.
REQ-028 After REQ-027, i_bus_data=A,B,C -> o_nibble A,B,C with valid pulses at phase 2; o_bus_pc 12348.
REQ-029 LOAD_PC with only 3 data entries -> busy stays high, no strobes after 3rd nibble; 2 more entries -> completes.
REQ-030 Command entry 1_4 during ADDR, or code 1_7 -> o_error=1 next clock, strobes stop, held until reset.
REQ-031 Assert i_reset asynchronously mid-ADDR -> all outputs 0 without clock edge; replay REQ-027 -> identical result.
REQ-032 Read pointer at 30, two-entry program spanning 30,31 then 0 -> pointer wraps to 0, no error.
